// File: rtl/i2c_bus_arbiter.sv
// Two-master arbiter for one open-drain I2C pin pair: synchronises the pins, tracks START/STOP,
// grants only on a free bus and forces release of an owner whose SCL stops moving.
module i2c_bus_arbiter #(
  parameter int SYNC_STAGES    = 2,
  parameter int IDLE_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o,
  input  logic       m0_scl_oe_i,
  input  logic       m0_sda_oe_i,
  input  logic       m1_scl_oe_i,
  input  logic       m1_sda_oe_i,
  input  logic       scl_in_i,
  input  logic       sda_in_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  output logic       scl_sync_o,
  output logic       sda_sync_o,
  output logic       bus_busy_o,
  output logic       timeout_err_o
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_RECOVER} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic                   last_owner_q, last_owner_d;
  logic                   tmo_err_q, tmo_err_d;
  logic [SYNC_STAGES-1:0] scl_ff_q, sda_ff_q;
  logic                   scl_p_q, sda_p_q;
  logic                   bus_busy_q;
  logic [IW-1:0]          idle_q;
  logic [TW-1:0]          tmo_q;

  logic scl_s, sda_s, start_det, stop_det, bus_free, tmo_fire, win;

  assign scl_s     = scl_ff_q[SYNC_STAGES-1];
  assign sda_s     = sda_ff_q[SYNC_STAGES-1];
  assign start_det = scl_p_q & scl_s & sda_p_q & ~sda_s;
  assign stop_det  = scl_p_q & scl_s & ~sda_p_q & sda_s;
  assign bus_free  = (idle_q == IDLE_MAX);
  assign tmo_fire  = (state_q == S_OWN) && (tmo_q == TMO_MAX);

  // Bus monitor and counters run in every state so foreign traffic is always seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_ff_q   <= '1;
      sda_ff_q   <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      bus_busy_q <= 1'b0;
      idle_q     <= '0;
      tmo_q      <= '0;
    end else begin
      scl_ff_q <= {scl_ff_q[SYNC_STAGES-2:0], scl_in_i};
      sda_ff_q <= {sda_ff_q[SYNC_STAGES-2:0], sda_in_i};
      scl_p_q  <= scl_s;
      sda_p_q  <= sda_s;

      if (tmo_fire)       bus_busy_q <= 1'b0;
      else if (start_det) bus_busy_q <= 1'b1;
      else if (stop_det)  bus_busy_q <= 1'b0;

      if (tmo_fire)
        idle_q <= '0;
      else if (!bus_busy_q && scl_s && sda_s) begin
        if (idle_q != IDLE_MAX) idle_q <= idle_q + 1'b1;
      end else
        idle_q <= '0;

      if (tmo_fire || state_q != S_OWN || !bus_busy_q || scl_s != scl_p_q)
        tmo_q <= '0;
      else if (tmo_q != TMO_MAX)
        tmo_q <= tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    tmo_err_d    = 1'b0;
    win          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus_free && req_i != 2'b00) begin
          // On a tie the master that did not own the bus last time wins.
          if (req_i == 2'b01)      win = 1'b0;
          else if (req_i == 2'b10) win = 1'b1;
          else                     win = ~last_owner_q;
          grant_d      = win ? 2'b10 : 2'b01;
          last_owner_d = win;
          state_d      = S_OWN;
        end
      end
      S_OWN: begin
        if (tmo_fire) begin
          grant_d   = 2'b00;
          tmo_err_d = 1'b1;
          state_d   = S_RECOVER;
        end else if (!req_i[grant_q[1]] && !bus_busy_q) begin
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      S_RECOVER: begin
        if (bus_free) state_d = S_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    scl_oe_o = 1'b0;
    sda_oe_o = 1'b0;
    if (grant_q == 2'b01) begin
      scl_oe_o = m0_scl_oe_i;
      sda_oe_o = m0_sda_oe_i;
    end else if (grant_q == 2'b10) begin
      scl_oe_o = m1_scl_oe_i;
      sda_oe_o = m1_sda_oe_i;
    end
  end

  assign grant_o       = grant_q;
  assign scl_sync_o    = scl_s;
  assign sda_sync_o    = sda_s;
  assign bus_busy_o    = bus_busy_q;
  assign timeout_err_o = tmo_err_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with an open-drain pin model (pin low if any driver pulls).
module tb_i2c_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] grant;
  logic       m0_scl_oe = 1'b0, m0_sda_oe = 1'b0, m1_scl_oe = 1'b0, m1_sda_oe = 1'b0;
  logic       ext_scl = 1'b0, ext_sda = 1'b0;
  logic       scl_pin, sda_pin, scl_oe, sda_oe, scl_sync, sda_sync, bus_busy, timeout_err;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;

  assign scl_pin = ~(scl_oe | ext_scl);
  assign sda_pin = ~(sda_oe | ext_sda);

  i2c_bus_arbiter #(.SYNC_STAGES(2), .IDLE_CYCLES(64), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .grant_o(grant),
    .m0_scl_oe_i(m0_scl_oe), .m0_sda_oe_i(m0_sda_oe),
    .m1_scl_oe_i(m1_scl_oe), .m1_sda_oe_i(m1_sda_oe),
    .scl_in_i(scl_pin), .sda_in_i(sda_pin),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .scl_sync_o(scl_sync), .sda_sync_o(sda_sync),
    .bus_busy_o(bus_busy), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the cycle count at which grant reached exp, or -1 if the budget ran out.
  task automatic wait_grant(input logic [1:0] exp, input int budget, output int at);
    int n;
    n = 0;
    while (grant !== exp && n < budget) begin
      tick();
      n++;
    end
    at = (grant === exp) ? cyc : -1;
  endtask

  initial begin
    int c0, at;
    int bad_hold;
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, at, bad_hold;
    ticks(3);
    check("rst_grant", grant, 2'b00);
    check("rst_scl_oe", scl_oe, 1'b0);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_tmo", timeout_err, 1'b0);
    check("rst_scl_sync", scl_sync, 1'b1);
    check("rst_sda_sync", sda_sync, 1'b1);
    rst = 1'b0;

    // 1: single request, pin routing from the owner only
    ticks(70);
    req = 2'b10;
    #1 check("t1_grant_before", grant, 2'b00);
    tick();
    check("t1_grant", grant, 2'b10);
    m1_scl_oe = 1'b1; m0_sda_oe = 1'b1;
    #1 check("t1_scl_oe", scl_oe, 1'b1);
    check("t1_sda_oe_m0_ignored", sda_oe, 1'b0);
    m1_scl_oe = 1'b0; m1_sda_oe = 1'b1; m0_sda_oe = 1'b0;
    #1 check("t1_scl_oe_rel", scl_oe, 1'b0);
    check("t1_sda_oe", sda_oe, 1'b1);
    tick();
    m1_sda_oe = 1'b0;
    ticks(4);
    check("t1_not_busy", bus_busy, 1'b0);
    req = 2'b00;
    tick();
    check("t1_release", grant, 2'b00);

    // 2: tie after reset goes to M1, then round-robin, then handover
    rst = 1'b1; tick(); rst = 1'b0;
    ticks(70);
    req = 2'b11; tick();
    check("t2_tie_first", grant, 2'b10);
    req = 2'b00; tick();
    check("t2_release", grant, 2'b00);
    ticks(70);
    req = 2'b11; tick();
    check("t2_round_robin", grant, 2'b01);
    req = 2'b10; tick();
    check("t2_handover_idle", grant, 2'b00);
    tick();
    check("t2_handover_grant", grant, 2'b10);
    req = 2'b00; tick();
    req = 2'b01; tick();
    check("t2_m0_again", grant, 2'b01);

    // 3: M0 transaction is not preempted; M1 waits for STOP plus idle time
    m0_sda_oe = 1'b1;
    ticks(4);
    check("t3_busy", bus_busy, 1'b1);
    req = 2'b11;
    m1_scl_oe = 1'b1;
    tick();
    check("t3_no_preempt", grant, 2'b01);
    check("t3_m1_scl_ignored", scl_oe, 1'b0);
    check("t3_m0_sda", sda_oe, 1'b1);
    m1_scl_oe = 1'b0;
    m0_sda_oe = 1'b0;
    c0 = cyc;
    ticks(4);
    check("t3_stop", bus_busy, 1'b0);
    req = 2'b10; tick();
    check("t3_release", grant, 2'b00);
    wait_grant(2'b10, 200, at);
    check("t3_grant_delay", at - c0, 68);

    // 4: M1 hangs with SCL low after START; timeout forces recovery
    m1_sda_oe = 1'b1;
    ticks(4);
    check("t4_busy", bus_busy, 1'b1);
    m1_scl_oe = 1'b1;
    c0 = cyc;
    tick();
    req = 2'b00;
    bad_hold = 0;
    for (int i = 0; i < 300 && timeout_err !== 1'b1; i++) begin
      if (grant !== 2'b10) bad_hold++;
      tick();
    end
    check("t4_hold_until_tmo", bad_hold, 0);
    check("t4_tmo_delay", cyc - c0, 104);
    check("t4_tmo_pulse", timeout_err, 1'b1);
    check("t4_tmo_grant", grant, 2'b00);
    check("t4_tmo_busy", bus_busy, 1'b0);
    check("t4_tmo_scl_oe", scl_oe, 1'b0);
    c0 = cyc;
    m1_scl_oe = 1'b0; m1_sda_oe = 1'b0;
    req = 2'b10;
    tick();
    check("t4_pulse_once", timeout_err, 1'b0);
    wait_grant(2'b10, 200, at);
    check("t4_regrant_delay", at - c0, 68);
    req = 2'b00; tick();
    check("t4_release", grant, 2'b00);

    // 5: foreign START blocks grants; non-owner oe never reaches the pins
    ext_sda = 1'b1;
    ticks(4);
    check("t5_ext_busy", bus_busy, 1'b1);
    req = 2'b01;
    m0_sda_oe = 1'b1; m1_scl_oe = 1'b1;
    bad_hold = 0;
    for (int i = 0; i < 100; i++) begin
      if (grant !== 2'b00 || scl_oe !== 1'b0 || sda_oe !== 1'b0) bad_hold++;
      tick();
    end
    check("t5_blocked", bad_hold, 0);
    m0_sda_oe = 1'b0; m1_scl_oe = 1'b0;
    ext_sda = 1'b0;
    c0 = cyc;
    wait_grant(2'b01, 200, at);
    check("t5_grant_delay", at - c0, 68);

    // 6: reset in mid-transaction releases everything at once
    m0_sda_oe = 1'b1;
    ticks(4);
    check("t6_busy", bus_busy, 1'b1);
    check("t6_grant", grant, 2'b01);
    rst = 1'b1; tick();
    check("t6_rst_grant", grant, 2'b00);
    check("t6_rst_scl_oe", scl_oe, 1'b0);
    check("t6_rst_sda_oe", sda_oe, 1'b0);
    check("t6_rst_busy", bus_busy, 1'b0);
    check("t6_rst_tmo", timeout_err, 1'b0);
    rst = 1'b0;
    m0_sda_oe = 1'b0;
    req = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
